// File: rtl/tx_credit_sched_pkg.sv
// tx_sched_pkg: shared definitions for the credit-aware TLP transmit scheduler.
//   - data path / length / requester-count constants
//   - TLP type and scheduler state encodings
//   - infinite-credit flag bit positions for header and data credit counts
//   - dw_to_credits(): payload length in DW to 16-byte data credits
package tx_sched_pkg;

    localparam int c_DATA_WIDTH = 16;
    localparam int c_LEN_W      = 10;
    localparam int c_NUM_REQ    = 4;

    typedef enum logic [1:0] {
        TLP_P    = 2'b00,
        TLP_NP   = 2'b01,
        TLP_CPL  = 2'b10,
        TLP_RSVD = 2'b11
    } tlp_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_REQ  = 2'd2,
        ST_XFER = 2'd3
    } sched_state_e;

    // Bit set in a credit count means "unlimited".
    localparam int HDR_INF_BIT  = 8;
    localparam int DATA_INF_BIT = 12;

    // One data credit covers 4 DW; widen to 11 bits first so 1023+3 does not wrap.
    function automatic logic [10:0] dw_to_credits(input logic [c_LEN_W-1:0] len);
        logic [10:0] sum;
        sum = {1'b0, len} + 11'd3;
        return sum >> 2;
    endfunction

endpackage

// File: rtl/tx_credit_sched_if.sv
// tx_credit_sched_if: bundle of the requester bus, the core VC0 TX port and the
// advertised transmit credits.
//   slave  modport: the scheduler (consumes requests/credits, drives grants and TX data)
//   master modport: the environment (requesters + PCIe core)
interface tx_credit_sched_if;
    import tx_sched_pkg::*;

    // Requester side, packed per requester.
    logic [c_NUM_REQ-1:0]              req_i;
    logic [2*c_NUM_REQ-1:0]            type_i;
    logic [c_LEN_W*c_NUM_REQ-1:0]      len_i;
    logic [c_DATA_WIDTH*c_NUM_REQ-1:0] din_i;
    logic [c_NUM_REQ-1:0]              sop_i;
    logic [c_NUM_REQ-1:0]              eop_i;
    logic [c_NUM_REQ-1:0]              rdy_o;

    // Core TX port.
    logic                    tx_req;
    logic                    tx_rdy;
    logic [c_DATA_WIDTH-1:0] tx_data;
    logic                    tx_st;
    logic                    tx_end;

    // Advertised credits and recheck pulses.
    logic [8:0]  tx_ca_ph;
    logic [8:0]  tx_ca_nph;
    logic [8:0]  tx_ca_cplh;
    logic [12:0] tx_ca_pd;
    logic [12:0] tx_ca_npd;
    logic [12:0] tx_ca_cpld;
    logic        tx_ca_p_recheck;
    logic        tx_ca_cpl_recheck;

    logic [1:0]  gnt_id;

    modport slave (
        input  req_i, type_i, len_i, din_i, sop_i, eop_i,
        input  tx_rdy,
        input  tx_ca_ph, tx_ca_nph, tx_ca_cplh, tx_ca_pd, tx_ca_npd, tx_ca_cpld,
        input  tx_ca_p_recheck, tx_ca_cpl_recheck,
        output rdy_o, tx_req, tx_data, tx_st, tx_end, gnt_id
    );

    modport master (
        output req_i, type_i, len_i, din_i, sop_i, eop_i,
        output tx_rdy,
        output tx_ca_ph, tx_ca_nph, tx_ca_cplh, tx_ca_pd, tx_ca_npd, tx_ca_cpld,
        output tx_ca_p_recheck, tx_ca_cpl_recheck,
        input  rdy_o, tx_req, tx_data, tx_st, tx_end, gnt_id
    );

endinterface

// File: rtl/tx_credit_sched_rr_pick4.sv
// rr_pick4: combinational 4-way rotating-priority picker.
//   eligible[3:0] : candidate mask
//   ptr[1:0]      : highest-priority index this round; scan goes upward, wrapping 3->0
//   valid         : at least one candidate
//   idx[1:0]      : winning index (0 when !valid)
module rr_pick4 (
    input  logic [3:0] eligible,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    // rot[k] is the candidate k places after the pointer.
    logic [3:0] rot;
    logic [1:0] off;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign rot[gi] = eligible[2'(ptr + 2'(gi))];
        end
    endgenerate

    always_comb begin
        off = 2'd0;
        if (rot[0])      off = 2'd0;
        else if (rot[1]) off = 2'd1;
        else if (rot[2]) off = 2'd2;
        else if (rot[3]) off = 2'd3;
    end

    assign valid = |rot;
    assign idx   = valid ? 2'(ptr + off) : 2'd0;

endmodule

// File: rtl/tx_credit_sched.sv
// tx_credit_sched: credit-aware round-robin TLP transmit scheduler for the
// PCIe core VC0 TX port.
//   clk_125 : core clock
//   rstn    : asynchronous active-low reset
//   bus     : requester bus (req/type/len/din/sop/eop in, rdy_o out), core TX
//             port (tx_req/tx_data/tx_st/tx_end out, tx_rdy in), advertised
//             credits and recheck pulses, gnt_id debug output.
// A requester is only granted when its whole TLP fits the advertised credits;
// the grant is held for the full TLP, and before data starts flowing a recheck
// pulse for the granted class can withdraw it.
module tx_credit_sched
    import tx_sched_pkg::*;
(
    input  logic              clk_125,
    input  logic              rstn,
    tx_credit_sched_if.slave  bus
);

    sched_state_e state_reg;
    logic [1:0]   sel_reg;
    logic [1:0]   ptr_reg;
    logic [1:0]   gnt_id_reg;
    logic         tx_req_reg;

    // Header credit availability does not depend on the requester.
    logic hdr_p_ok, hdr_np_ok, hdr_cpl_ok;
    assign hdr_p_ok   = bus.tx_ca_ph[HDR_INF_BIT]   | (bus.tx_ca_ph[7:0]   != 8'd0);
    assign hdr_np_ok  = bus.tx_ca_nph[HDR_INF_BIT]  | (bus.tx_ca_nph[7:0]  != 8'd0);
    assign hdr_cpl_ok = bus.tx_ca_cplh[HDR_INF_BIT] | (bus.tx_ca_cplh[7:0] != 8'd0);

    logic [c_NUM_REQ-1:0] elig;

    generate
        for (genvar gi = 0; gi < c_NUM_REQ; gi++) begin : g_elig
            logic [1:0]         req_type;
            logic [c_LEN_W-1:0] req_len;
            logic [10:0]        need;
            logic               pd_ok, npd_ok, cpld_ok;

            assign req_type = bus.type_i[2*gi +: 2];
            assign req_len  = bus.len_i[c_LEN_W*gi +: c_LEN_W];
            assign need     = dw_to_credits(req_len);

            assign pd_ok   = bus.tx_ca_pd[DATA_INF_BIT]   | (bus.tx_ca_pd[11:0]   >= {1'b0, need});
            assign npd_ok  = bus.tx_ca_npd[DATA_INF_BIT]  | (bus.tx_ca_npd[11:0]  >= {1'b0, need});
            assign cpld_ok = bus.tx_ca_cpld[DATA_INF_BIT] | (bus.tx_ca_cpld[11:0] >= {1'b0, need});

            // Reserved type matches none of the terms, so it is never eligible.
            assign elig[gi] = bus.req_i[gi] & (
                  ((req_type == TLP_P)   & hdr_p_ok   & pd_ok)
                | ((req_type == TLP_NP)  & hdr_np_ok  & ((req_len == '0) | npd_ok))
                | ((req_type == TLP_CPL) & hdr_cpl_ok & cpld_ok));
        end
    endgenerate

    logic       pick_valid;
    logic [1:0] pick_idx;

    rr_pick4 u_pick (
        .eligible (elig),
        .ptr      (ptr_reg),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    // Recheck classes: p_recheck covers posted and non-posted, cpl_recheck completions.
    logic [1:0] sel_type;
    logic       recheck_hit;
    logic       withdraw;

    assign sel_type    = bus.type_i[{sel_reg, 1'b0} +: 2];
    assign recheck_hit = (sel_type == TLP_CPL) ? bus.tx_ca_cpl_recheck : bus.tx_ca_p_recheck;
    assign withdraw    = (recheck_hit & ~elig[sel_reg]) | ~bus.req_i[sel_reg];

    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= ST_IDLE;
            sel_reg    <= 2'd0;
            ptr_reg    <= 2'd0;
            gnt_id_reg <= 2'd0;
            tx_req_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|elig) state_reg <= ST_ARB;
                end
                ST_ARB: begin
                    // Credits may have changed since IDLE; fall back if nothing fits now.
                    if (pick_valid) begin
                        sel_reg    <= pick_idx;
                        gnt_id_reg <= pick_idx;
                        tx_req_reg <= 1'b1;
                        state_reg  <= ST_REQ;
                    end else begin
                        state_reg  <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // Withdrawal leaves the pointer alone so the requester keeps its turn.
                    if (withdraw) begin
                        tx_req_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end else if (bus.tx_rdy) begin
                        tx_req_reg <= 1'b0;
                        state_reg  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    // Committed: recheck pulses are not looked at here.
                    if (bus.tx_rdy & bus.eop_i[sel_reg]) begin
                        ptr_reg   <= 2'(sel_reg + 2'd1);
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Data path is a pure mux on the registered select: no added latency, and a
    // stalled core (tx_rdy low) sees zero data and no framing.
    logic xfer_act;
    assign xfer_act = (state_reg == ST_XFER) & bus.tx_rdy;

    assign bus.rdy_o   = xfer_act ? (4'b0001 << sel_reg) : 4'b0000;
    assign bus.tx_data = xfer_act ? bus.din_i[{sel_reg, 4'b0000} +: c_DATA_WIDTH] : '0;
    assign bus.tx_st   = xfer_act & bus.sop_i[sel_reg];
    assign bus.tx_end  = xfer_act & bus.eop_i[sel_reg];
    assign bus.tx_req  = tx_req_reg;
    assign bus.gnt_id  = gnt_id_reg;

endmodule

// File: tb/tb_tx_credit_sched.sv
// Scoreboard bench for tx_credit_sched: each directed test pushes the beats it
// expects (in the hand-derived grant order) and a negedge monitor pops one entry
// per accepted beat.
module tb_tx_credit_sched;
    import tx_sched_pkg::*;

    logic clk_125 = 1'b0;
    logic rstn    = 1'b0;

    tx_credit_sched_if bus ();

    tx_credit_sched dut (
        .clk_125 (clk_125),
        .rstn    (rstn),
        .bus     (bus.slave)
    );

    always #4 clk_125 = ~clk_125;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] data;
        logic        st;
        logic        en;
        int          gap;   // required negedges since previous eop beat, 0 = unchecked
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    int    last_eop_cyc = 0;

    // Requester models: npk packets left, current packet number / word / length.
    int npk [4];
    int pnum[4];
    int pos [4];
    int plen[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < 4; i++) begin
            logic on;
            on = (npk[i] > 0);
            bus.req_i[i]          = on;
            bus.din_i[16*i +: 16] = on ? {2'(i), 6'(pnum[i]), 8'(pos[i])} : 16'h0;
            bus.sop_i[i]          = on && (pos[i] == 0);
            bus.eop_i[i]          = on && (pos[i] == plen[i] - 1);
        end
    endtask

    task automatic step();
        logic [3:0] acc;
        @(negedge clk_125);
        acc = bus.rdy_o;
        @(posedge clk_125);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                pos[i]++;
                if (pos[i] == plen[i]) begin
                    pos[i] = 0;
                    pnum[i]++;
                    npk[i]--;
                end
            end
        end
        drive_src();
    endtask

    task automatic load(input int i, input logic [1:0] typ, input int len, input int words, input int count);
        bus.type_i[2*i +: 2]  = typ;
        bus.len_i[10*i +: 10] = 10'(len);
        plen[i] = words;
        npk[i]  = count;
        pos[i]  = 0;
        drive_src();
    endtask

    task automatic expect_pkt(input int id, input int p, input int words, input int nbeats, input int gap);
        for (int w = 0; w < nbeats; w++) begin
            beat_t b;
            b.id   = 2'(id);
            b.data = {2'(id), 6'(p), 8'(w)};
            b.st   = (w == 0);
            b.en   = (w == words - 1);
            b.gap  = (w == 0) ? gap : 0;
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_size(input int target, input string name);
        int n = 0;
        while (exp_q.size() != target && n < 300) begin
            step();
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'(target));
    endtask

    task automatic set_credits(input logic [8:0] ph, input logic [12:0] pd,
                               input logic [8:0] nph, input logic [12:0] npd,
                               input logic [8:0] cplh, input logic [12:0] cpld);
        bus.tx_ca_ph = ph;   bus.tx_ca_pd = pd;
        bus.tx_ca_nph = nph; bus.tx_ca_npd = npd;
        bus.tx_ca_cplh = cplh; bus.tx_ca_cpld = cpld;
    endtask

    task automatic do_reset(input string name);
        rstn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            npk[i] = 0; pnum[i] = 0; pos[i] = 0; plen[i] = 1;
        end
        bus.type_i = '0;
        bus.len_i  = '0;
        drive_src();
        repeat (2) @(posedge clk_125);
        #1;
        chk({name, "_rst_outs"},
            {52'd0, bus.tx_req, bus.tx_st, bus.tx_end, bus.rdy_o, bus.gnt_id, 3'd0},
            64'd0);
        chk({name, "_rst_data"}, 64'(bus.tx_data), 64'd0);
        rstn = 1'b1;
    endtask

    // Monitor: one entry per accepted beat; otherwise the core bus must be quiet.
    initial begin
        forever begin
            @(negedge clk_125);
            cyc++;
            if (bus.rdy_o != 4'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=rdy_o %b data %h required=no beat",
                             bus.rdy_o, bus.tx_data);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    $display("beat id=%0d data=%h st=%0b end=%0b", bus.gnt_id, bus.tx_data,
                             bus.tx_st, bus.tx_end);
                    chk("beat",
                        {36'd0, bus.rdy_o, bus.gnt_id, bus.tx_data, bus.tx_st, bus.tx_end, bus.tx_rdy},
                        {36'd0, 4'(4'b0001 << e.id), e.id, e.data, e.st, e.en, 1'b1});
                    if (e.gap != 0)
                        chk("pkt_gap", 64'(cyc - last_eop_cyc), 64'(e.gap));
                end
                if (bus.tx_end) last_eop_cyc = cyc;
            end else begin
                chk("quiet_bus", {46'd0, bus.tx_data, bus.tx_st, bus.tx_end}, 64'd0);
            end
        end
    end

    initial begin
        bus.req_i = '0; bus.type_i = '0; bus.len_i = '0; bus.din_i = '0;
        bus.sop_i = '0; bus.eop_i = '0;
        bus.tx_rdy = 1'b1;
        bus.tx_ca_p_recheck = 1'b0;
        bus.tx_ca_cpl_recheck = 1'b0;
        set_credits(9'd0, 13'd0, 9'd0, 13'd0, 9'd0, 13'd0);

        // 1: single posted TLP, then pointer check (req1 ahead of req0).
        do_reset("t1");
        set_credits(9'd5, 13'd2, 9'd0, 13'd0, 9'd0, 13'd0);
        load(0, TLP_P, 8, 4, 1);
        expect_pkt(0, 0, 4, 4, 0);
        step();
        chk("t1_req_n1", 64'(bus.tx_req), 64'd0);
        step();
        chk("t1_req_n2", {62'd0, bus.tx_req, 1'b0} | 64'(bus.gnt_id), {62'd0, 1'b1, 1'b0});
        wait_size(0, "t1_drain");
        load(0, TLP_P, 8, 4, 1);
        load(1, TLP_P, 8, 4, 1);
        expect_pkt(1, 0, 4, 4, 0);
        expect_pkt(0, 1, 4, 4, 4);
        wait_size(0, "t1_ptr_drain");

        // 2: round-robin between two completion requesters.
        do_reset("t2");
        set_credits(9'd0, 13'd0, 9'd0, 13'd0, 9'h100, 13'h1000);
        load(0, TLP_CPL, 6, 6, 2);
        load(3, TLP_CPL, 6, 6, 2);
        expect_pkt(0, 0, 6, 6, 0);
        expect_pkt(3, 0, 6, 6, 4);
        expect_pkt(0, 1, 6, 6, 4);
        expect_pkt(3, 1, 6, 6, 4);
        wait_size(0, "t2_drain");

        // 3: credit starvation of a posted write while a completion fits.
        do_reset("t3");
        set_credits(9'd1, 13'd3, 9'd0, 13'd0, 9'd1, 13'd1);
        load(1, TLP_P, 16, 4, 1);
        load(3, TLP_CPL, 1, 4, 1);
        expect_pkt(3, 0, 4, 4, 0);
        wait_size(0, "t3_cpl_drain");
        repeat (5) step();
        chk("t3_withheld", 64'(bus.tx_req), 64'd0);
        bus.tx_ca_pd = 13'd4;
        expect_pkt(1, 0, 4, 4, 0);
        wait_size(0, "t3_p_drain");

        // 4: recheck withdrawal in REQ keeps the pointer.
        do_reset("t4");
        set_credits(9'd1, 13'd100, 9'd0, 13'd0, 9'd0, 13'd0);
        bus.tx_rdy = 1'b0;
        load(0, TLP_P, 4, 4, 1);
        step();
        step();
        chk("t4_req_up", 64'(bus.tx_req), 64'd1);
        bus.tx_ca_ph = 9'd0;
        bus.tx_ca_p_recheck = 1'b1;
        step();
        bus.tx_ca_p_recheck = 1'b0;
        chk("t4_req_drop", 64'(bus.tx_req), 64'd0);
        repeat (3) step();
        chk("t4_idle", {62'd0, bus.tx_req, 1'b0} | 64'(bus.gnt_id), 64'd0);
        bus.tx_ca_ph = 9'd1;
        bus.tx_rdy = 1'b1;
        load(1, TLP_P, 4, 4, 1);
        expect_pkt(0, 0, 4, 4, 0);
        expect_pkt(1, 0, 4, 4, 4);
        wait_size(0, "t4_drain");

        // 5: stall mid-packet, then reset mid-packet.
        do_reset("t5");
        set_credits(9'd0, 13'd0, 9'd0, 13'd0, 9'd1, 13'd1);
        load(2, TLP_CPL, 2, 8, 1);
        expect_pkt(2, 0, 8, 8, 0);
        wait_size(5, "t5_pre_stall");
        bus.tx_rdy = 1'b0;
        repeat (3) begin
            @(negedge clk_125);
            chk("t5_stall", {43'd0, bus.rdy_o, bus.tx_data, bus.tx_st, bus.tx_end}, 64'd0);
        end
        @(posedge clk_125);
        #1;
        bus.tx_rdy = 1'b1;
        wait_size(0, "t5_resume");
        load(2, TLP_CPL, 2, 8, 1);
        expect_pkt(2, 1, 8, 2, 0);
        wait_size(0, "t5_pre_reset");
        chk("t5_mid_pkt", 64'(bus.rdy_o), 64'd4);
        rstn = 1'b0;
        #1;
        chk("t5_async_rst",
            {38'd0, bus.tx_req, bus.tx_st, bus.tx_end, bus.rdy_o, bus.gnt_id, bus.tx_data},
            64'd0);

        // 6: reserved type is never granted and never blocks.
        do_reset("t6");
        set_credits(9'h100, 13'h1000, 9'h100, 13'h1000, 9'h100, 13'h1000);
        load(2, TLP_RSVD, 0, 4, 1);
        load(0, TLP_P, 4, 4, 2);
        expect_pkt(0, 0, 4, 4, 0);
        expect_pkt(0, 1, 4, 4, 4);
        wait_size(0, "t6_drain");
        repeat (6) step();
        chk("t6_rsvd_idle", {62'd0, bus.tx_req, 1'b0} | 64'(bus.gnt_id), 64'd0);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
